// File: rtl/motion_pkg.sv
// Shared widths and the centroid FSM state type for the motion centroid path.
package motion_pkg;

    localparam int CNT_W         = 19;
    localparam int SUM_W_DEFAULT = 28;

    typedef enum logic [1:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        PUBLISH
    } cent_state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The start cycle already
// performs the first step, so a W-bit divide occupies exactly W cycles.
module seq_divider #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_reg;
    logic [W-1:0]  quo_reg;
    logic [W-1:0]  dsr_reg;
    logic [CW-1:0] step_reg;
    logic          busy_reg;

    logic [W-1:0]  rem_in;
    logic [W-1:0]  quo_in;
    logic [W-1:0]  dsr_in;
    logic [W:0]    trial;
    logic          trial_ok;
    logic [W-1:0]  rem_next;
    logic [W-1:0]  quo_next;
    logic          last_step;

    // quo_reg shifts the dividend out at the top while quotient bits enter at the bottom
    always_comb begin
        rem_in    = start ? '0 : rem_reg;
        quo_in    = start ? dividend : quo_reg;
        dsr_in    = start ? divisor : dsr_reg;
        trial     = {rem_in, quo_in[W-1]};
        trial_ok  = (trial >= {1'b0, dsr_in});
        rem_next  = trial_ok ? W'(trial - {1'b0, dsr_in}) : trial[W-1:0];
        quo_next  = {quo_in[W-2:0], trial_ok};
        last_step = busy_reg && !start && (step_reg == CW'(W - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dsr_reg  <= '0;
            step_reg <= '0;
            busy_reg <= 1'b0;
        end else if (start || busy_reg) begin
            rem_reg  <= rem_next;
            quo_reg  <= quo_next;
            dsr_reg  <= dsr_in;
            step_reg <= start ? CW'(1) : step_reg + CW'(1);
            busy_reg <= !last_step;
        end
    end

    // done marks the cycle committing the final bit; quotient is valid from the next cycle
    assign busy     = busy_reg;
    assign done     = last_step;
    assign quotient = quo_reg;

endmodule

// File: rtl/motion_centroid_accum.sv
// Per-frame centre of mass of motion pixels: accumulate during the scan, divide
// during blanking, publish a stable centroid for the following frame.
module motion_centroid_accum
    import motion_pkg::*;
#(
    parameter int IMG_W     = 160,
    parameter int IMG_H     = 120,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int MIN_COUNT = 16,
    parameter int SUM_W     = SUM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DE,
    input  logic [9:0]       x_pixel,
    input  logic [9:0]       y_pixel,
    input  logic             motion_flag,
    output logic [9:0]       com_x,
    output logic [9:0]       com_y,
    output logic             com_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] motion_count,
    output logic             overrun
);

    localparam logic [9:0]       IMG_W_L  = 10'(IMG_W);
    localparam logic [9:0]       IMG_H_L  = 10'(IMG_H);
    localparam logic [9:0]       X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]       Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_COUNT);

    cent_state_t      state_reg, state_next;

    logic             hit;
    logic             fe;
    logic [SUM_W-1:0] sum_x_reg, sum_y_reg;
    logic [SUM_W-1:0] sum_x_inc, sum_y_inc;
    logic [CNT_W-1:0] cnt_reg, cnt_inc;

    logic [SUM_W-1:0] snap_sum_x_reg, snap_sum_y_reg;
    logic [CNT_W-1:0] snap_cnt_reg;
    logic             snap_valid;

    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [SUM_W-1:0] div_dividend;
    logic [SUM_W-1:0] div_quotient;
    logic [9:0]       quot_x_reg;
    logic             unused_quot_hi;

    logic [9:0]       com_x_reg, com_y_reg;
    logic             com_valid_reg;
    logic             frame_done_reg;
    logic [CNT_W-1:0] motion_count_reg;
    logic             overrun_reg;

    // The _inc values fold in the current pixel, so the frame-end pixel lands in its own frame
    always_comb begin
        hit       = DE && motion_flag && (x_pixel < IMG_W_L) && (y_pixel < IMG_H_L);
        fe        = DE && (x_pixel == X_LAST) && (y_pixel == Y_LAST);
        sum_x_inc = sum_x_reg + (hit ? SUM_W'(x_pixel) : '0);
        sum_y_inc = sum_y_reg + (hit ? SUM_W'(y_pixel) : '0);
        cnt_inc   = cnt_reg + (hit ? CNT_W'(1) : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_x_reg <= '0;
            sum_y_reg <= '0;
            cnt_reg   <= '0;
        end else if (fe) begin
            sum_x_reg <= '0;
            sum_y_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            sum_x_reg <= sum_x_inc;
            sum_y_reg <= sum_y_inc;
            cnt_reg   <= cnt_inc;
        end
    end

    // A frame end that finds the FSM busy is dropped; only the overrun pulse records it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_sum_x_reg <= '0;
            snap_sum_y_reg <= '0;
            snap_cnt_reg   <= '0;
        end else if (fe && (state_reg == IDLE)) begin
            snap_sum_x_reg <= sum_x_inc;
            snap_sum_y_reg <= sum_y_inc;
            snap_cnt_reg   <= cnt_inc;
        end
    end

    assign snap_valid = (snap_cnt_reg >= MIN_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_start    = 1'b0;
        div_dividend = snap_sum_x_reg;
        case (state_reg)
            IDLE: begin
                if (fe) begin
                    state_next = (cnt_inc >= MIN_CNT) ? DIV_X : PUBLISH;
                end
            end
            DIV_X: begin
                div_start = !div_busy;
                if (div_done) begin
                    state_next = DIV_Y;
                end
            end
            DIV_Y: begin
                div_start    = !div_busy;
                div_dividend = snap_sum_y_reg;
                if (div_done) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    seq_divider #(
        .W(SUM_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (SUM_W'(snap_cnt_reg)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Quotient never exceeds the image size, so only the low 10 bits carry information
    assign unused_quot_hi = ^div_quotient[SUM_W-1:10];

    // X result is still on the divider output during the cycle that starts the Y divide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quot_x_reg <= '0;
        end else if ((state_reg == DIV_Y) && div_start) begin
            quot_x_reg <= div_quotient[9:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            com_x_reg        <= '0;
            com_y_reg        <= '0;
            com_valid_reg    <= 1'b0;
            frame_done_reg   <= 1'b0;
            motion_count_reg <= '0;
            overrun_reg      <= 1'b0;
        end else begin
            frame_done_reg <= (state_reg == PUBLISH);
            overrun_reg    <= fe && (state_reg != IDLE);
            if (state_reg == PUBLISH) begin
                motion_count_reg <= snap_cnt_reg;
                com_valid_reg    <= snap_valid;
                if (snap_valid) begin
                    com_x_reg <= quot_x_reg;
                    com_y_reg <= div_quotient[9:0];
                end
            end
        end
    end

    assign com_x        = com_x_reg;
    assign com_y        = com_y_reg;
    assign com_valid    = com_valid_reg;
    assign frame_done   = frame_done_reg;
    assign motion_count = motion_count_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_motion_centroid_accum.sv
// Random and directed frames against an arithmetic centroid model; two DUT
// configurations (160x120/MIN 16 and 640x480/MIN 1) share the same pixel stream.
module tb_motion_centroid_accum;

    localparam int SW       = 28;
    localparam int LAT_DIV  = 2 * SW + 2;
    localparam int LAT_SKIP = 2;
    localparam int WAIT_MAX = 70;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       mf;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        de = 1'b0;
    logic [9:0]  x_pixel = '0;
    logic [9:0]  y_pixel = '0;
    logic        motion_flag = 1'b0;

    logic [9:0]  cx [2];
    logic [9:0]  cy [2];
    logic        cv [2];
    logic        fd [2];
    logic [18:0] mc [2];
    logic        ov [2];

    always #5 clk = ~clk;

    motion_centroid_accum dut_a (
        .clk          (clk),
        .reset        (reset),
        .DE           (de),
        .x_pixel      (x_pixel),
        .y_pixel      (y_pixel),
        .motion_flag  (motion_flag),
        .com_x        (cx[0]),
        .com_y        (cy[0]),
        .com_valid    (cv[0]),
        .frame_done   (fd[0]),
        .motion_count (mc[0]),
        .overrun      (ov[0])
    );

    motion_centroid_accum #(
        .IMG_W     (640),
        .IMG_H     (480),
        .MIN_COUNT (1)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .DE           (de),
        .x_pixel      (x_pixel),
        .y_pixel      (y_pixel),
        .motion_flag  (motion_flag),
        .com_x        (cx[1]),
        .com_y        (cy[1]),
        .com_valid    (cv[1]),
        .frame_done   (fd[1]),
        .motion_count (mc[1]),
        .overrun      (ov[1])
    );

    int     img_w   [2] = '{160, 640};
    int     img_h   [2] = '{120, 480};
    int     min_cnt [2] = '{16, 1};

    longint m_sx [2], m_sy [2], m_cnt [2];
    longint snap_sx [2], snap_sy [2], snap_cnt [2];
    int     exp_cx [2], exp_cy [2];

    int     checks = 0;
    int     failures = 0;
    int     edge_cnt = 0;
    int     fe_edge = 0;
    int     fd_pulses [2], fd_edge [2], ov_pulses [2];
    pix_t   frame_q [$];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
        for (int i = 0; i < 2; i++) begin
            if (fd[i]) begin
                fd_pulses[i]++;
                fd_edge[i] = edge_cnt;
            end
            if (ov[i]) ov_pulses[i]++;
        end
    endtask

    task automatic set_pix(input int x, input int y, input bit d, input bit m);
        x_pixel     = 10'(x);
        y_pixel     = 10'(y);
        de          = d;
        motion_flag = m;
    endtask

    // Reference: a pixel counts when enabled, flagged, and inside the configured image
    task automatic model_pix(input int x, input int y, input bit d, input bit m);
        for (int i = 0; i < 2; i++) begin
            if (d && m && x < img_w[i] && y < img_h[i]) begin
                m_sx[i]  += x;
                m_sy[i]  += y;
                m_cnt[i] += 1;
            end
        end
    endtask

    task automatic add_pix(input int x, input int y, input bit d, input bit m);
        pix_t p;
        p.x  = 10'(x);
        p.y  = 10'(y);
        p.de = d;
        p.mf = m;
        frame_q.push_back(p);
    endtask

    task automatic send_frame(input bit fe_mf);
        foreach (frame_q[k]) begin
            set_pix(int'(frame_q[k].x), int'(frame_q[k].y), frame_q[k].de, frame_q[k].mf);
            model_pix(int'(frame_q[k].x), int'(frame_q[k].y), frame_q[k].de, frame_q[k].mf);
            tick();
        end
        set_pix(639, 479, 1'b1, fe_mf);
        model_pix(639, 479, 1'b1, fe_mf);
        for (int i = 0; i < 2; i++) begin
            snap_sx[i]   = m_sx[i];
            snap_sy[i]   = m_sy[i];
            snap_cnt[i]  = m_cnt[i];
            m_sx[i]      = 0;
            m_sy[i]      = 0;
            m_cnt[i]     = 0;
            fd_pulses[i] = 0;
            ov_pulses[i] = 0;
            fd_edge[i]   = -1000;
        end
        fe_edge = edge_cnt;
        tick();
        set_pix(0, 0, 1'b0, 1'b0);
    endtask

    task automatic finish_frame(input string tag, input int exp_ov);
        bit v;
        for (int k = 0; k < WAIT_MAX; k++) tick();
        for (int i = 0; i < 2; i++) begin
            v = (snap_cnt[i] >= min_cnt[i]);
            if (v) begin
                exp_cx[i] = int'(snap_sx[i] / snap_cnt[i]);
                exp_cy[i] = int'(snap_sy[i] / snap_cnt[i]);
            end
            check_eq($sformatf("%s[%0d] frame_done_pulses", tag, i), fd_pulses[i], 1);
            check_eq($sformatf("%s[%0d] latency", tag, i), fd_edge[i] - fe_edge, v ? LAT_DIV : LAT_SKIP);
            check_eq($sformatf("%s[%0d] overrun_pulses", tag, i), ov_pulses[i], exp_ov);
            check_eq($sformatf("%s[%0d] motion_count", tag, i), mc[i], snap_cnt[i]);
            check_eq($sformatf("%s[%0d] com_valid", tag, i), cv[i], v);
            check_eq($sformatf("%s[%0d] com_x", tag, i), cx[i], exp_cx[i]);
            check_eq($sformatf("%s[%0d] com_y", tag, i), cy[i], exp_cy[i]);
        end
        $display("frame %s cnt=%0d/%0d com_a=(%0d,%0d) com_b=(%0d,%0d)",
                 tag, snap_cnt[0], snap_cnt[1], cx[0], cy[0], cx[1], cy[1]);
    endtask

    task automatic play_frame(input string tag, input bit fe_mf);
        send_frame(fe_mf);
        finish_frame(tag, 0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s[%0d] com_x", tag, i), cx[i], 0);
            check_eq($sformatf("%s[%0d] com_y", tag, i), cy[i], 0);
            check_eq($sformatf("%s[%0d] com_valid", tag, i), cv[i], 0);
            check_eq($sformatf("%s[%0d] frame_done", tag, i), fd[i], 0);
            check_eq($sformatf("%s[%0d] motion_count", tag, i), mc[i], 0);
            check_eq($sformatf("%s[%0d] overrun", tag, i), ov[i], 0);
        end
    endtask

    task automatic load_block();
        frame_q.delete();
        for (int yy = 20; yy < 24; yy++)
            for (int xx = 10; xx < 14; xx++)
                add_pix(xx, yy, 1'b1, 1'b1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0;
            exp_cx[i] = 0; exp_cy[i] = 0;
        end

        #1 reset = 1'b1;
        #2;
        check_all_zero("reset_async");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset_release");

        frame_q.delete();
        add_pix(100, 50, 1'b1, 1'b1);
        play_frame("single_hit", 1'b0);

        load_block();
        play_frame("block4x4", 1'b0);

        frame_q.delete();
        add_pix(30, 30, 1'b0, 1'b1);
        add_pix(31, 30, 1'b1, 1'b0);
        play_frame("no_hits", 1'b0);

        frame_q.delete();
        add_pix(200, 10, 1'b1, 1'b1);
        add_pix(10, 130, 1'b1, 1'b1);
        add_pix(5, 5, 1'b1, 1'b1);
        play_frame("outside", 1'b0);

        frame_q.delete();
        play_frame("fe_hit", 1'b1);

        frame_q.delete();
        for (int k = 0; k < 15; k++) add_pix(30 + k, 60, 1'b1, 1'b1);
        play_frame("min_minus1", 1'b0);

        frame_q.delete();
        for (int k = 0; k < 16; k++) add_pix(30 + k, 60, 1'b1, 1'b1);
        add_pix(159, 119, 1'b1, 1'b1);
        add_pix(160, 119, 1'b1, 1'b1);
        add_pix(159, 120, 1'b1, 1'b1);
        play_frame("min_exact_edges", 1'b0);

        // Second frame end ten cycles after the first: its pixels and its snapshot are dropped
        load_block();
        send_frame(1'b0);
        for (int k = 1; k < 10; k++) begin
            set_pix($urandom_range(0, 150), $urandom_range(0, 110), 1'b1, 1'b1);
            tick();
        end
        set_pix(639, 479, 1'b1, 1'b1);
        tick();
        set_pix(0, 0, 1'b0, 1'b0);
        finish_frame("overrun", 1);

        frame_q.delete();
        add_pix(40, 40, 1'b1, 1'b1);
        play_frame("after_overrun", 1'b0);

        // Reset lands while both instances are in the Y divide
        load_block();
        send_frame(1'b0);
        for (int k = 0; k < 39; k++) tick();
        for (int i = 0; i < 2; i++)
            check_eq($sformatf("pre_reset[%0d] frame_done_pulses", i), fd_pulses[i], 0);
        reset = 1'b1;
        #2;
        check_all_zero("reset_div_y");
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_cx[i] = 0;
            exp_cy[i] = 0;
        end
        load_block();
        add_pix(120, 100, 1'b1, 1'b1);
        play_frame("post_reset", 1'b0);

        for (int f = 0; f < 8; f++) begin
            frame_q.delete();
            n = $urandom_range(8, 36);
            for (int k = 0; k < n; k++)
                add_pix($urandom_range(0, 200), $urandom_range(0, 140),
                        $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
            play_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
